// File: rtl/led_matrix_scroller.sv
// led_matrix_scroller: LED dot-matrix driver with a scrolling COLS-wide window.
//
// Holds a ROWS x PAT_W display pattern, scans the window one column at a time
// (active-low column select, active-high row drive) and moves the window left or
// right once every SCROLL_DIV frames, wrapping around the pattern ends.
// Pattern rows are written into a shadow buffer. A commit pulse copies the whole
// shadow buffer into the display buffer at the next frame boundary, so a frame is
// never drawn from a half-updated pattern.
//
// Load handshake: a row write happens on every clk edge where load_valid and
// load_ready are both high. load_ready is low only while a commit is pending.
// load_valid may be held high without a matching write, and load_row/load_data
// are sampled only on that edge. Rows at or above ROWS are accepted and dropped.
//
// Optional feature (compile-time macro GHOST_BLANK_EN): when defined, the first
// cycle of every column slot is blanked so that the previous column cannot ghost.
module led_matrix_scroller #(
  parameter int ROWS       = 5,
  parameter int COLS       = 7,
  parameter int PAT_W      = 16,
  parameter int SCAN_DIV   = 1000,
  parameter int SCROLL_DIV = 50
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [1:0]                          mode,
  input  logic                                load_valid,
  output logic                                load_ready,
  input  logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] load_row,
  input  logic [PAT_W-1:0]                    load_data,
  input  logic                                commit,
  output logic [ROWS-1:0]                     row_data,
  output logic [COLS-1:0]                     col_sel,
  output logic                                frame_start
);

  localparam int CW       = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int OFF_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SCROLL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;
  localparam logic [1:0] MODE_BLANK = 2'b11;

  logic [SCAN_W-1:0]   scan_cnt;
  logic [CW-1:0]       col_idx;
  logic [SCROLL_W-1:0] scroll_cnt;
  logic [OFF_W-1:0]    offset;
  logic                pending;
  logic [PAT_W-1:0]    shadow [ROWS];
  logic [PAT_W-1:0]    disp   [ROWS];

  logic                scan_last;
  logic                col_last;
  logic                boundary;
  logic                scroll_last;
  logic                blank_now;
  logic [OFF_W:0]      pix_sum;
  logic [OFF_W-1:0]    pix_idx;
  logic [ROWS-1:0]     row_next;
  logic [COLS-1:0]     col_next;

  assign scan_last   = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign col_last    = (col_idx == CW'(COLS - 1));
  assign boundary    = scan_last && col_last;
  assign scroll_last = (scroll_cnt == SCROLL_W'(SCROLL_DIV - 1));
  assign load_ready  = ~pending;

  // Pattern column under the scanned column: (offset + col_idx) mod PAT_W.
  // Both terms are below PAT_W, so a single conditional subtract wraps it.
  always_comb begin
    pix_sum = {1'b0, offset} + (OFF_W + 1)'(col_idx);
    if (pix_sum >= (OFF_W + 1)'(PAT_W)) begin
      pix_idx = OFF_W'(pix_sum - (OFF_W + 1)'(PAT_W));
    end else begin
      pix_idx = pix_sum[OFF_W-1:0];
    end
    for (int r = 0; r < ROWS; r++) begin
      row_next[r] = disp[r][pix_idx];
    end
    for (int c = 0; c < COLS; c++) begin
      col_next[c] = (int'(col_idx) != c);
    end
  end

  // Blank the matrix in mode 11 and, with anti-ghosting, on each slot's first cycle.
  always_comb begin
    blank_now = (mode == MODE_BLANK);
`ifdef GHOST_BLANK_EN
    if (scan_cnt == '0) begin
      blank_now = 1'b1;
    end
`endif
  end

  // Column scan: each column holds for SCAN_DIV cycles, then the next one is selected.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      col_idx  <= '0;
    end else if (scan_last) begin
      scan_cnt <= '0;
      col_idx  <= col_last ? '0 : col_idx + CW'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Scroll: count frame boundaries and step the window with the mode seen on the step cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      scroll_cnt <= '0;
      offset     <= '0;
    end else if (boundary) begin
      if (scroll_last) begin
        scroll_cnt <= '0;
        if (mode == MODE_LEFT) begin
          offset <= (offset == OFF_W'(PAT_W - 1)) ? '0 : offset + OFF_W'(1);
        end else if (mode == MODE_RIGHT) begin
          offset <= (offset == '0) ? OFF_W'(PAT_W - 1) : offset - OFF_W'(1);
        end
      end else begin
        scroll_cnt <= scroll_cnt + SCROLL_W'(1);
      end
    end
  end

  // Buffers: writes land in the shadow; a pending commit copies it to the display at a boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        shadow[r] <= '0;
        disp[r]   <= '0;
      end
    end else begin
      if (load_valid && load_ready && (int'(load_row) < ROWS)) begin
        shadow[load_row] <= load_data;
      end
      if (pending && boundary) begin
        pending <= 1'b0;
        for (int r = 0; r < ROWS; r++) begin
          disp[r] <= shadow[r];
        end
      end else if (commit) begin
        pending <= 1'b1;
      end
    end
  end

  // Registered matrix drive, one cycle behind the scan state.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_data    <= '0;
      col_sel     <= '1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= (col_idx == '0) && (scan_cnt == '0);
      if (blank_now) begin
        row_data <= '0;
        col_sel  <= '1;
      end else begin
        row_data <= row_next;
        col_sel  <= col_next;
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scroller.sv
// tb_led_matrix_scroller: directed bench for led_matrix_scroller with
// ROWS=5, COLS=7, PAT_W=16, SCAN_DIV=2, SCROLL_DIV=1 (one scroll step per frame).
// Build with GHOST_BLANK_EN defined to check the anti-ghosting variant.
module tb_led_matrix_scroller;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic        load_valid;
  logic        load_ready;
  logic [2:0]  load_row;
  logic [15:0] load_data;
  logic        commit;
  logic [4:0]  row_data;
  logic [6:0]  col_sel;
  logic        frame_start;

  int          n_checks;
  int          n_pass;

  // Expected display contents and window offset, maintained by hand.
  logic [15:0] exp_pat [5];
  int          exp_off;

  led_matrix_scroller #(
    .ROWS(5), .COLS(7), .PAT_W(16), .SCAN_DIV(2), .SCROLL_DIV(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_row(load_row),
    .load_data(load_data),
    .commit(commit),
    .row_data(row_data),
    .col_sel(col_sel),
    .frame_start(frame_start)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] exp_rows(input int c);
    logic [4:0] v;
    int idx;
    idx = (exp_off + c) % 16;
    for (int r = 0; r < 5; r++) begin
      v[r] = exp_pat[r][idx];
    end
    return v;
  endfunction

  function automatic logic [6:0] exp_sel(input int c);
    logic [6:0] v;
    v = 7'h7F;
    v[c] = 1'b0;
    return v;
  endfunction

  // Step until frame_start is seen, bounded.
  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_start && n < 40);
    check_eq("frame_start_seen", frame_start, 1);
  endtask

  // Check samples 0..12 of the next frame; the boundary edge is left untaken so a
  // mode set afterwards is the one sampled on that boundary.
  task automatic run_frame();
    int c;
    wait_fs();
    for (int i = 0; i < 13; i++) begin
      if (i > 0) step();
      c = i / 2;
`ifdef GHOST_BLANK_EN
      if (i % 2 == 0) begin
        check_eq($sformatf("ghost_sel_o%0d_c%0d", exp_off, c), col_sel, 7'h7F);
        check_eq($sformatf("ghost_row_o%0d_c%0d", exp_off, c), row_data, 5'b0);
      end else begin
        check_eq($sformatf("sel_o%0d_c%0d", exp_off, c), col_sel, exp_sel(c));
        check_eq($sformatf("row_o%0d_c%0d", exp_off, c), row_data, exp_rows(c));
      end
`else
      check_eq($sformatf("sel_o%0d_c%0d", exp_off, c), col_sel, exp_sel(c));
      check_eq($sformatf("row_o%0d_c%0d", exp_off, c), row_data, exp_rows(c));
`endif
    end
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    mode       = 2'b00;
    load_valid = 1'b0;
    load_row   = 3'd0;
    load_data  = 16'h0;
    commit     = 1'b0;
    exp_off    = 0;
    for (int r = 0; r < 5; r++) exp_pat[r] = 16'h0;

    // Reset state and first scan columns
    step(); step(); step();
    check_eq("rst_col_sel", col_sel, 7'h7F);
    check_eq("rst_row_data", row_data, 5'b0);
    check_eq("rst_load_ready", load_ready, 1);
    check_eq("rst_frame_start", frame_start, 0);
    rst = 1'b0;
    step();
    check_eq("first_frame_start", frame_start, 1);
`ifdef GHOST_BLANK_EN
    check_eq("first_col_sel", col_sel, 7'h7F);
`else
    check_eq("first_col_sel", col_sel, 7'h7E);
`endif
    step();
    check_eq("col0_hold_sel", col_sel, 7'h7E);
    check_eq("col0_hold_fs", frame_start, 0);
    step();
`ifdef GHOST_BLANK_EN
    check_eq("col1_first_sel", col_sel, 7'h7F);
`else
    check_eq("col1_first_sel", col_sel, 7'h7D);
`endif
    step();
    check_eq("col1_second_sel", col_sel, 7'h7D);

    // Load two rows and commit; display only changes at the boundary
    load_valid = 1'b1; load_row = 3'd0; load_data = 16'h0001;
    step();
    load_row = 3'd4; load_data = 16'h8000;
    step();
    load_valid = 1'b0; commit = 1'b1;
    step();
    commit = 1'b0;
    check_eq("pending_ready_low", load_ready, 0);
    check_eq("no_write_through", row_data, 5'b0);
    exp_pat[0] = 16'h0001;
    exp_pat[4] = 16'h8000;
    run_frame();
    check_eq("swap_ready_high", load_ready, 1);

    // Scroll left 16 frames, wrapping back to offset 0
    mode = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      exp_off = k % 16;
      run_frame();
    end

    // Scroll right from offset 0 to 15, then hold
    mode = 2'b10;
    exp_off = 15;
    run_frame();
    mode = 2'b00;

    // Blank mid-frame, then resume in phase with offset unchanged
    wait_fs();
    mode = 2'b11;
    step();
    check_eq("blank_sel_1", col_sel, 7'h7F);
    check_eq("blank_row_1", row_data, 5'b0);
    step();
    check_eq("blank_sel_2", col_sel, 7'h7F);
    mode = 2'b00;
    step();
    check_eq("resume_sel", col_sel, 7'h7D);
    check_eq("resume_row", row_data, 5'b00001);
    for (int i = 0; i < 9; i++) step();
    run_frame();

    // Out-of-range row write is accepted and dropped
    load_valid = 1'b1; load_row = 3'd5; load_data = 16'hFFFF;
    step();
    load_valid = 1'b0;
    check_eq("row5_ready", load_ready, 1);
    run_frame();

    // Write plus commit in one cycle, then a second commit while pending
    wait_fs();
    load_valid = 1'b1; load_row = 3'd2; load_data = 16'h0002; commit = 1'b1;
    step();
    load_valid = 1'b0; commit = 1'b0;
    check_eq("commit2_ready_low", load_ready, 0);
    commit = 1'b1;
    step();
    commit = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check_eq("still_pending", load_ready, 0);
    exp_pat[2] = 16'h0002;
    run_frame();
    check_eq("second_commit_ignored", load_ready, 1);

    // Reset with a commit pending discards the swap and clears both buffers
    load_valid = 1'b1; load_row = 3'd0; load_data = 16'hFFFF; commit = 1'b1;
    step();
    load_valid = 1'b0; commit = 1'b0;
    rst = 1'b1;
    step(); step();
    check_eq("midrst_col_sel", col_sel, 7'h7F);
    check_eq("midrst_row_data", row_data, 5'b0);
    check_eq("midrst_ready", load_ready, 1);
    rst = 1'b0;
    exp_off = 0;
    for (int r = 0; r < 5; r++) exp_pat[r] = 16'h0;
    run_frame();
    run_frame();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
